neuron: RTL and testbench
=========================

NEURON -- requirements
Module: neuron

Interface
REQ-001 The module SHALL have parameter N, default 18, meaning accumulator and output width in bits.
REQ-002 The module SHALL have parameter M, default 4, meaning number of input/weight pairs per computation.
REQ-003 The module SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on the rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit, meaning reset, asynchronous and active-low.
REQ-005 The module SHALL have port start, input, 1 bit, meaning request to begin a new M-pair computation.
REQ-006 The module SHALL have port in, input, 8 bits, unsigned, meaning the current neuron input sample.
REQ-007 The module SHALL have port weight, input, 8 bits, unsigned, meaning the weight paired with in.
REQ-008 The module SHALL have port out, output, N bits, meaning the registered weighted sum of the last completed computation.
REQ-009 The module SHALL have port ready, output, 1 bit, meaning out holds a freshly completed result.

Function
REQ-010 The FSM SHALL have four states: IDLE, LOAD, ACC and DONE.
- IDLE: start=1 -> LOAD, clear accumulator and pair counter; else stay.
REQ-011 LOAD SHALL capture in and weight into internal registers and go to ACC; one pair is consumed per LOAD visit.
REQ-012 ACC SHALL add the 16-bit unsigned product of the captured registers, zero-extended to N bits, to the accumulator, then increment the counter.
- After the M-th pair -> DONE; else -> LOAD.
REQ-013 Each pair SHALL take exactly 2 cycles, so a computation takes 1 + 2*M rising edges from the start edge in IDLE to DONE entry (9 for M=4).
REQ-014 On the ACC->DONE transition, out SHALL load the final sum; out SHALL otherwise hold its value, including during a later computation.
REQ-015 ready SHALL be 1 exactly while in DONE and 0 in all other states.
REQ-016 DONE: start=1 -> LOAD with accumulator and counter cleared, giving back-to-back operation with a one-cycle ready pulse; start=0 -> stay in DONE.
REQ-017 start SHALL be ignored in LOAD and ACC.
REQ-018 Accumulator arithmetic SHALL be unsigned modulo 2^N (wrap), unless REQ-022 applies.
REQ-019 The counter SHALL be sized ceil(log2(M+1)) bits; M >= 1 is required.

Reset
REQ-020 While rst=0, asynchronously: state=IDLE, accumulator=0, counter=0, captured registers=0, out=0, ready=0.
REQ-021 A reset asserted mid-computation SHALL abort the computation with no partial result reaching out.

Configuration
REQ-022 With macro NEURON_SATURATE_EN defined, the accumulator SHALL clamp at 2^N-1 whenever an addition would exceed it.
- Without the macro: plain wrap-around per REQ-018.
- Interface and timing SHALL be identical in both builds.

Structure
REQ-023 Package neuron_pkg SHALL hold the FSM state enum type and the constant DATA_W = 8 (input/weight width).
REQ-024 The multiply-add datapath (product, extension, add/saturate) SHALL be sub-module neuron_mac; the FSM, counter and output registers SHALL stay in neuron.

Verification
REQ-025 Nominal: N=18, M=4, start=1 from reset release; pairs (3,6), (2,2), (3,26), (7,10), each applied before its LOAD edge -> out=170, ready=1 at the 9th edge.
REQ-026 Maximum: N=18, M=4, all pairs (255,255) -> out=260100 with no overflow.
REQ-027 Overflow: N=16, M=4, all pairs (255,255) -> out=63492 without NEURON_SATURATE_EN; out=65535 with it.
REQ-028 Reset mid-operation: rst=0 after the second pair's ACC -> out=0, ready=0, state IDLE; a fresh nominal run then yields 170.
REQ-029 Back-to-back: start held high through DONE -> ready pulses one cycle; out holds 170 until the second run of all-(1,1) pairs completes, then out=4.
REQ-030 Hold: start=0 in DONE for 10 cycles -> ready stays 1, out unchanged, in/weight changes ignored.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron block: FSM state encoding and data width.
package neuron_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/neuron_mac.sv
// Multiply-accumulate datapath: acc + (a*b) with N-bit wrap, or clamp to 2^N-1
// when NEURON_SATURATE_EN is defined.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int N = 18
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [N-1:0]      acc,
    output logic [N-1:0]      sum
);

    localparam int PW = 2 * DATA_W;

    logic [PW-1:0] prod;
    assign prod = a * b;

`ifdef NEURON_SATURATE_EN
    // One guard bit above the wider of accumulator and product catches the carry.
    localparam int EW = ((N > PW) ? N : PW) + 1;
    localparam logic [N-1:0] MAXV = {N{1'b1}};

    logic [EW-1:0] wide;
    assign wide = EW'(acc) + EW'(prod);
    assign sum  = (wide > EW'(MAXV)) ? MAXV : wide[N-1:0];
`else
    assign sum = acc + N'(prod);
`endif

endmodule

// File: rtl/neuron.sv
// Sequential M-pair weighted-sum neuron: IDLE/LOAD/ACC/DONE FSM, pair counter and
// registered output. Build option: NEURON_SATURATE_EN (clamp instead of wrap).
module neuron
    import neuron_pkg::*;
#(
    parameter int N = 18,
    parameter int M = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] in,
    input  logic [DATA_W-1:0] weight,
    output logic [N-1:0]      out,
    output logic              ready
);

    localparam int CW = (M < 1) ? 1 : $clog2(M + 1);

    state_t            state, state_nxt;
    logic [N-1:0]      acc;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] in_r, w_r;
    logic [N-1:0]      sum;
    logic              last;

    assign last  = (cnt == CW'(M - 1));
    assign ready = (state == DONE);

    neuron_mac #(.N(N)) u_mac (
        .a   (in_r),
        .b   (w_r),
        .acc (acc),
        .sum (sum)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = ACC;
            ACC:     state_nxt = last ? DONE : LOAD;
            DONE:    if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // out only moves on the final ACC, so an aborted run never leaks a partial sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc  <= '0;
            cnt  <= '0;
            in_r <= '0;
            w_r  <= '0;
            out  <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                LOAD: begin
                    in_r <= in;
                    w_r  <= weight;
                end
                ACC: begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                    if (last) out <= sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron.sv
// Directed bench for neuron: an N=18 and an N=16 instance share stimulus; checks
// nominal, hold, mid-run reset, back-to-back and full-scale/overflow runs.
module tb_neuron;
    import neuron_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in = '0;
    logic [7:0]  weight = '0;
    logic [17:0] out18;
    logic [15:0] out16;
    logic        rdy18, rdy16;

    int ncmp = 0;
    int nfail = 0;
    int exp18 = 0;
    int exp16 = 0;

    always #5 clk = ~clk;

    neuron #(.N(18), .M(4)) dut (
        .clk(clk), .rst(rst), .start(start), .in(in), .weight(weight),
        .out(out18), .ready(rdy18)
    );

    neuron #(.N(16), .M(4)) dut16 (
        .clk(clk), .rst(rst), .start(start), .in(in), .weight(weight),
        .out(out16), .ready(rdy16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: got %0d want %0d", tag, obs, expv);
        end
    endtask

    // Caller raises start before calling; first posedge here is the start edge.
    // Each pair is presented during its LOAD cycle and captured on the LOAD edge.
    task automatic run(input logic [3:0][7:0] a, input logic [3:0][7:0] b,
                       input int npairs, input logic keep);
        @(posedge clk);
        for (int i = 0; i < npairs; i++) begin
            @(negedge clk);
            start  = keep;
            in     = a[i];
            weight = b[i];
            chk("busy_ready18", 32'(rdy18), 32'd0);
            chk("busy_hold18", 32'(out18), 32'(exp18));
            chk("busy_hold16", 32'(out16), 32'(exp16));
            @(posedge clk);
            @(posedge clk);
        end
    endtask

    logic [3:0][7:0] nom_a, nom_b, one_v, max_v;

    initial begin
        nom_a = {8'd7, 8'd3, 8'd2, 8'd3};
        nom_b = {8'd10, 8'd26, 8'd2, 8'd6};
        one_v = {8'd1, 8'd1, 8'd1, 8'd1};
        max_v = {8'd255, 8'd255, 8'd255, 8'd255};

        // reset state
        #12;
        chk("rst_out18", 32'(out18), 32'd0);
        chk("rst_ready18", 32'(rdy18), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;

        // nominal: 3*6 + 2*2 + 3*26 + 7*10 = 170
        run(nom_a, nom_b, 4, 1'b0);
        @(negedge clk);
        chk("nom_out18", 32'(out18), 32'd170);
        chk("nom_out16", 32'(out16), 32'd170);
        chk("nom_ready", 32'(rdy18), 32'd1);
        exp18 = 170;
        exp16 = 170;

        // hold in DONE with start low; input changes are ignored
        for (int i = 0; i < 10; i++) begin
            in     = 8'($urandom);
            weight = 8'($urandom);
            @(negedge clk);
            chk("hold_ready", 32'(rdy18), 32'd1);
            chk("hold_out18", 32'(out18), 32'd170);
        end

        // reset after second pair's ACC aborts the run
        start = 1'b1;
        run(nom_a, nom_b, 2, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_out18", 32'(out18), 32'd0);
        chk("abort_out16", 32'(out16), 32'd0);
        chk("abort_ready", 32'(rdy18), 32'd0);
        chk("abort_state", 32'(dut.state), 32'(IDLE));
        chk("abort_acc", 32'(dut.acc), 32'd0);
        exp18 = 0;
        exp16 = 0;
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;

        // fresh nominal run with start held through DONE
        run(nom_a, nom_b, 4, 1'b1);
        @(negedge clk);
        chk("b2b1_out18", 32'(out18), 32'd170);
        chk("b2b1_ready", 32'(rdy18), 32'd1);
        exp18 = 170;
        exp16 = 170;

        // back-to-back all-(1,1); ready drops right after the one-cycle pulse
        run(one_v, one_v, 4, 1'b0);
        @(negedge clk);
        chk("b2b2_out18", 32'(out18), 32'd4);
        chk("b2b2_out16", 32'(out16), 32'd4);
        chk("b2b2_ready", 32'(rdy18), 32'd1);
        exp18 = 4;
        exp16 = 4;

        // full-scale: 4*65025 = 260100 fits 18 bits; N=16 wraps or clamps
        start = 1'b1;
        run(max_v, max_v, 4, 1'b0);
        @(negedge clk);
        chk("max_out18", 32'(out18), 32'd260100);
`ifdef NEURON_SATURATE_EN
        chk("ovf_out16", 32'(out16), 32'd65535);
`else
        chk("ovf_out16", 32'(out16), 32'd63492);
`endif
        chk("max_ready16", 32'(rdy16), 32'd1);
        @(negedge clk);
        chk("max_stay_done", 32'(dut.state), 32'(DONE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
